// File: rtl/feed_clutch_ctrl.sv
// Card-feed clutch controller: decides feed cycles at the decide angle,
// holds the latch magnet through the clutch sample, counts brush rows.
module feed_clutch_ctrl #(
  parameter int DECIDE_ANGLE = 300,
  parameter int LATCH_ANGLE  = 315,
  parameter int ROWS         = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       power,
  input  int         cont_angle,
  input  logic       sccb,
  input  logic       feed_req,
  input  logic       hopper_empty,
  output logic       clch_latch,
  output logic       feed_ack,
  output logic       busy,
  output logic       row_strobe,
  output logic [3:0] row_num,
  output logic       cycle_done,
  output logic       feed_check
);

  typedef enum logic [1:0] {
    IDLE,
    ENGAGE,
    RUN
  } state_t;

  localparam logic [3:0] ROWS_L = 4'(ROWS);

  state_t     state, state_n;
  logic       chain, chain_n;
  logic       sccb_d;
  logic       latch_n, ack_n, busy_n;
  logic       strobe_n, done_n, check_n;
  logic [3:0] row_n;

  logic decide, latch, rise, ok;

  assign decide = power && (cont_angle == DECIDE_ANGLE);
  assign latch  = power && (cont_angle == LATCH_ANGLE);
  assign rise   = power && sccb && !sccb_d;
  assign ok     = feed_req && !hopper_empty;

  always_comb begin
    state_n  = state;
    chain_n  = chain;
    latch_n  = clch_latch;
    ack_n    = 1'b0;
    strobe_n = 1'b0;
    done_n   = 1'b0;
    check_n  = feed_check;
    row_n    = row_num;
    unique case (state)
      IDLE: begin
        if (decide && ok) begin
          state_n = ENGAGE;
          latch_n = 1'b1;
          ack_n   = 1'b1;
        end
      end
      ENGAGE: begin
        if (latch) begin
          state_n = RUN;
          row_n   = 4'd0;
        end
      end
      RUN: begin
        if (rise) begin
          strobe_n = 1'b1;
          if (row_num != 4'hf)
            row_n = row_num + 4'd1;
        end
        if (decide) begin
          if (ok) begin
            ack_n   = 1'b1;
            chain_n = 1'b1;
          end else begin
            latch_n = 1'b0;
            chain_n = 1'b0;
          end
        end
        // End of cycle judges the count before any same-clock row edge
        if (latch) begin
          done_n  = 1'b1;
          chain_n = 1'b0;
          if (row_num != ROWS_L)
            check_n = 1'b1;
          if (chain) begin
            state_n = RUN;
            row_n   = 4'd0;
          end else begin
            state_n = IDLE;
            row_n   = row_num;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      chain      <= 1'b0;
      sccb_d     <= 1'b0;
      clch_latch <= 1'b0;
      feed_ack   <= 1'b0;
      busy       <= 1'b0;
      row_strobe <= 1'b0;
      row_num    <= 4'd0;
      cycle_done <= 1'b0;
      feed_check <= 1'b0;
    end else begin
      state      <= state_n;
      chain      <= chain_n;
      sccb_d     <= sccb;
      clch_latch <= latch_n;
      feed_ack   <= ack_n;
      busy       <= busy_n;
      row_strobe <= strobe_n;
      row_num    <= row_n;
      cycle_done <= done_n;
      feed_check <= check_n;
    end
  end

endmodule

// File: tb/tb_feed_clutch_ctrl.sv
// Randomised and directed bench for feed_clutch_ctrl against a
// feed-queue model of the clutch decisions.
module tb_feed_clutch_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       power;
  int         cont_angle;
  logic       sccb;
  logic       feed_req;
  logic       hopper_empty;
  logic       clch_latch;
  logic       feed_ack;
  logic       busy;
  logic       row_strobe;
  logic [3:0] row_num;
  logic       cycle_done;
  logic       feed_check;

  feed_clutch_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .power        (power),
    .cont_angle   (cont_angle),
    .sccb         (sccb),
    .feed_req     (feed_req),
    .hopper_empty (hopper_empty),
    .clch_latch   (clch_latch),
    .feed_ack     (feed_ack),
    .busy         (busy),
    .row_strobe   (row_strobe),
    .row_num      (row_num),
    .cycle_done   (cycle_done),
    .feed_check   (feed_check)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit queued, feeding, decided, chk_flag, sccb_prev, model_valid;
  int rows, pclk;
  bit e_latch, e_ack, e_busy, e_strobe, e_done;
  int e_row;

  always @(posedge clk) begin
    bit rise, ok;
    if (reset) begin
      queued = 0; feeding = 0; decided = 0; chk_flag = 0;
      rows = 0; sccb_prev = 0; model_valid = 1;
      e_ack = 0; e_strobe = 0; e_done = 0;
    end else begin
      e_ack = 0; e_strobe = 0; e_done = 0;
      if (power) begin
        pclk++;
        rise = sccb && !sccb_prev;
        ok = feed_req && !hopper_empty;
        if (cont_angle == 315 && (feeding || queued)) begin
          if (feeding) begin
            e_done = 1;
            e_strobe = rise;
            if (rows != 12) chk_flag = 1;
          end
          if (queued) rows = 0;
          feeding = queued;
          queued = 0;
          decided = 0;
        end else begin
          if (feeding && rise) begin
            e_strobe = 1;
            rows = (rows < 15) ? rows + 1 : 15;
          end
          if (cont_angle == 300 && !queued) begin
            if (feeding) decided = 1;
            if (ok) begin
              queued = 1;
              e_ack = 1;
            end
          end
        end
      end
      sccb_prev = sccb;
    end
    e_latch = queued || (feeding && !decided);
    e_busy = queued || feeding;
    e_row = rows;
  end

  // ---------------- compare / monitor ----------------
  int n_ack, n_strobe, n_done, n_busy, n_hi, n_fall, n_badrow;
  int done_row, done_chk, done_gap, last_done;
  int prev_row;
  bit prev_latch;

  always @(negedge clk) begin
    if (model_valid) begin
      chk("clch_latch", clch_latch, e_latch);
      chk("feed_ack", feed_ack, e_ack);
      chk("busy", busy, e_busy);
      chk("row_strobe", row_strobe, e_strobe);
      chk("row_num", row_num, e_row);
      chk("cycle_done", cycle_done, e_done);
      chk("feed_check", feed_check, chk_flag);
      if (feed_ack) n_ack++;
      if (row_strobe) n_strobe++;
      if (busy) n_busy++;
      if (clch_latch) n_hi++;
      if (prev_latch && !clch_latch) n_fall++;
      if (cycle_done) begin
        n_done++;
        done_row = prev_row;
        done_chk = feed_check;
        if (prev_row != 12) n_badrow++;
        if (last_done >= 0) done_gap = pclk - last_done;
        last_done = pclk;
      end
      prev_row = row_num;
      prev_latch = clch_latch;
    end
  end

  // ---------------- stimulus ----------------
  int miss_idx = -1;
  bit rnd_glitch = 0;

  function automatic logic sccb_at(int a, int miss);
    int c, k;
    c = (a - 315 + 360) % 360;
    if (c < 12) return 1'b0;
    k = (c - 12) / 18;
    if (k > 11 || k == miss) return 1'b0;
    return ((c - 12) % 18) < 9;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
    if (power) cont_angle = (cont_angle + 1) % 360;
    sccb = sccb_at(cont_angle, miss_idx) |
           (rnd_glitch && $urandom_range(0, 40) == 0);
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_to(int a);
    int n = 0;
    do begin
      tick();
      n++;
    end while (cont_angle != a && n < 1000);
    if (cont_angle != a) begin
      checks++;
      errors++;
      $display("FAIL run_to: angle %0d expected %0d", cont_angle, a);
    end
  endtask

  task automatic clr();
    n_ack = 0; n_strobe = 0; n_done = 0; n_busy = 0;
    n_hi = 0; n_fall = 0; n_badrow = 0;
    done_row = -1; done_chk = -1; done_gap = -1; last_done = -1;
  endtask

  task automatic single_feed();
    run_to(200);
    clr();
    feed_req = 1;
    run_to(301);
    feed_req = 0;
    run_to(320);
    run_to(320);
  endtask

  initial begin
    reset = 1; power = 1; cont_angle = 0; sccb = 0;
    feed_req = 0; hopper_empty = 0;
    clr();
    ticks(3);
    chk("reset clch_latch", clch_latch, 0);
    chk("reset busy", busy, 0);
    chk("reset row_num", row_num, 0);
    chk("reset feed_check", feed_check, 0);
    reset = 0;

    // single feed
    single_feed();
    chk("single acks", n_ack, 1);
    chk("single strobes", n_strobe, 12);
    chk("single dones", n_done, 1);
    chk("single close rows", done_row, 12);
    chk("single close check", done_chk, 0);
    chk("single idle busy", busy, 0);

    // no request, then empty hopper
    clr();
    ticks(360);
    feed_req = 1;
    hopper_empty = 1;
    ticks(360);
    feed_req = 0;
    hopper_empty = 0;
    chk("noreq acks", n_ack, 0);
    chk("noreq strobes", n_strobe, 0);
    chk("noreq busy", n_busy, 0);
    chk("noreq latch", n_hi, 0);

    // chained feeds
    run_to(200);
    clr();
    feed_req = 1;
    run_to(301);
    run_to(301);
    feed_req = 0;
    run_to(320);
    run_to(320);
    chk("chain acks", n_ack, 2);
    chk("chain dones", n_done, 2);
    chk("chain gap", done_gap, 360);
    chk("chain bad rows", n_badrow, 0);
    chk("chain latch drops", n_fall, 1);
    chk("chain check", feed_check, 0);

    // power drops at latch and mid-cycle
    run_to(200);
    clr();
    feed_req = 1;
    run_to(301);
    feed_req = 0;
    run_to(315);
    power = 0;
    ticks(50);
    power = 1;
    run_to(55);
    power = 0;
    ticks(50);
    power = 1;
    run_to(320);
    run_to(320);
    chk("pwr dones", n_done, 1);
    chk("pwr strobes", n_strobe, 12);
    chk("pwr close rows", done_row, 12);
    chk("pwr check", done_chk, 0);
    chk("pwr latch drops", n_fall, 1);

    // missing 5th row, then good cycle keeps the flag
    miss_idx = 4;
    single_feed();
    miss_idx = -1;
    chk("miss close rows", done_row, 11);
    chk("miss check", done_chk, 1);
    single_feed();
    chk("good after miss rows", done_row, 12);
    chk("sticky check", feed_check, 1);

    // reset mid-run
    run_to(200);
    feed_req = 1;
    run_to(301);
    feed_req = 0;
    run_to(55);
    reset = 1;
    tick();
    reset = 0;
    chk("midrst clch_latch", clch_latch, 0);
    chk("midrst busy", busy, 0);
    chk("midrst row_num", row_num, 0);
    chk("midrst feed_check", feed_check, 0);
    chk("midrst cycle_done", cycle_done, 0);
    single_feed();
    chk("post rst acks", n_ack, 1);
    chk("post rst rows", done_row, 12);
    chk("post rst check", done_chk, 0);

    // randomised traffic
    rnd_glitch = 1;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 99) == 0) feed_req = ~feed_req;
      if ($urandom_range(0, 299) == 0) hopper_empty = ~hopper_empty;
      if (power && $urandom_range(0, 199) == 0) power = 0;
      else if (!power && $urandom_range(0, 9) == 0) power = 1;
      if (cont_angle == 0)
        miss_idx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 11)) : -1;
      tick();
    end
    rnd_glitch = 0;
    power = 1;
    feed_req = 0;
    miss_idx = -1;
    ticks(800);
    chk("drain busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
